// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : irq_arbiter
// Brief    : Fixed-priority interrupt controller with claim/complete handshake.
// Revision : 1.0 - initial release
// ============================================================================
module irq_arbiter #(
    parameter int NUM_SRC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sel,
    input  logic [2:0]         addr,
    input  logic [31:0]        wdata,
    input  logic               wen,
    output logic [31:0]        rdata,
    input  logic [NUM_SRC-1:0] src_irq,
    output logic               irq
);

    localparam int       c_PAD             = 32 - NUM_SRC;
    localparam logic [2:0] c_ADDR_CTRL       = 3'd0;
    localparam logic [2:0] c_ADDR_ENABLE     = 3'd1;
    localparam logic [2:0] c_ADDR_TRIG       = 3'd2;
    localparam logic [2:0] c_ADDR_PENDING    = 3'd3;
    localparam logic [2:0] c_ADDR_CLAIM      = 3'd4;
    localparam logic [2:0] c_ADDR_COMPLETE   = 3'd5;
    localparam logic [2:0] c_ADDR_IN_SERVICE = 3'd6;

    logic               ctrl_q, ctrl_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] trig_q, trig_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;
    logic [NUM_SRC-1:0] src_dly_q;
    logic [31:0]        rdata_q, rdata_d;

    logic               w_rd, w_wr;
    logic [NUM_SRC-1:0] w_claimable;
    logic [NUM_SRC-1:0] w_winner_oh;
    logic [4:0]         w_claim_id;
    logic [NUM_SRC-1:0] w_claim_mask;
    logic [NUM_SRC-1:0] w_complete_mask;
    logic [NUM_SRC-1:0] w_w1c_mask;
    logic [NUM_SRC-1:0] w_edge_set;
    logic [NUM_SRC-1:0] w_set;
    logic [31:0]        w_rd_val;

    assign w_rd        = sel & ~wen;
    assign w_wr        = sel & wen;
    assign w_claimable = pending_q & enable_q & ~in_service_q;

    // Scan from the top down so the lowest claimable index is the last assignment.
    always_comb begin
        w_winner_oh = '0;
        w_claim_id  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_claimable[i]) begin
                w_winner_oh    = '0;
                w_winner_oh[i] = 1'b1;
                w_claim_id     = 5'(i + 1);
            end
        end
    end

    always_comb begin
        w_complete_mask = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_complete_mask[i] = w_wr && (addr == c_ADDR_COMPLETE) &&
                                 (wdata == 32'(i + 1)) && in_service_q[i];
        end
    end

    always_comb begin
        w_rd_val = '0;
        case (addr)
            c_ADDR_CTRL:       w_rd_val = {31'd0, ctrl_q};
            c_ADDR_ENABLE:     w_rd_val = {{c_PAD{1'b0}}, enable_q};
            c_ADDR_TRIG:       w_rd_val = {{c_PAD{1'b0}}, trig_q};
            c_ADDR_PENDING:    w_rd_val = {{c_PAD{1'b0}}, pending_q};
            c_ADDR_CLAIM:      w_rd_val = {27'd0, w_claim_id};
            c_ADDR_IN_SERVICE: w_rd_val = {{c_PAD{1'b0}}, in_service_q};
            default:           w_rd_val = '0;
        endcase
    end

    assign w_claim_mask = (w_rd && (addr == c_ADDR_CLAIM))   ? w_winner_oh         : '0;
    assign w_w1c_mask   = (w_wr && (addr == c_ADDR_PENDING)) ? wdata[NUM_SRC-1:0]  : '0;
    assign w_edge_set   = trig_q & src_irq & ~src_dly_q;
    assign w_set        = w_edge_set | (~trig_q & src_irq & ~in_service_q);

    // Set beats W1C; claim beats set unless an edge source sees a fresh edge.
    assign pending_d    = ((pending_q & ~w_w1c_mask) | w_set) & ~(w_claim_mask & ~w_edge_set);
    assign in_service_d = (in_service_q | w_claim_mask) & ~w_complete_mask;

    assign ctrl_d   = (w_wr && (addr == c_ADDR_CTRL))   ? wdata[0]           : ctrl_q;
    assign enable_d = (w_wr && (addr == c_ADDR_ENABLE)) ? wdata[NUM_SRC-1:0] : enable_q;
    assign trig_d   = (w_wr && (addr == c_ADDR_TRIG))   ? wdata[NUM_SRC-1:0] : trig_q;
    assign rdata_d  = w_rd ? w_rd_val : rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q       <= 1'b0;
            enable_q     <= '0;
            trig_q       <= '0;
            pending_q    <= '0;
            in_service_q <= '0;
            src_dly_q    <= '0;
            rdata_q      <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            enable_q     <= enable_d;
            trig_q       <= trig_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            src_dly_q    <= src_irq;
            rdata_q      <= rdata_d;
        end
    end

    assign irq   = ctrl_q & (|w_claimable);
    assign rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// tb_irq_arbiter: register table, directed multi-cycle sequences and a
// randomized run against a per-source behavioural model.
module tb_irq_arbiter;

    localparam int N = 8;

    logic         clk;
    logic         rst_n;
    logic         sel;
    logic [2:0]   addr;
    logic [31:0]  wdata;
    logic         wen;
    logic [31:0]  rdata;
    logic [N-1:0] src_irq;
    logic         irq;

    int n_tests = 0;
    int n_fail  = 0;

    irq_arbiter #(.NUM_SRC(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sel     (sel),
        .addr    (addr),
        .wdata   (wdata),
        .wen     (wen),
        .rdata   (rdata),
        .src_irq (src_irq),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic         m_ctrl;
    logic [N-1:0] m_en, m_trig, m_pend, m_isv, m_srcd;
    logic [31:0]  m_rdata;

    task automatic model_reset();
        m_ctrl = 1'b0; m_en = '0; m_trig = '0; m_pend = '0;
        m_isv = '0; m_srcd = '0; m_rdata = '0;
    endtask

    function automatic int m_winner();
        for (int i = 0; i < N; i++)
            if (m_pend[i] && m_en[i] && !m_isv[i]) return i;
        return -1;
    endfunction

    function automatic logic m_irq();
        return m_ctrl && (m_winner() >= 0);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_step();
        int           win;
        int           id;
        logic         rd, wr, set;
        logic [N-1:0] np, ni;
        logic [31:0]  rv;
        if (!rst_n) return;
        rd  = sel && !wen;
        wr  = sel && wen;
        win = m_winner();
        case (addr)
            3'd0:    rv = {31'd0, m_ctrl};
            3'd1:    rv = 32'(m_en);
            3'd2:    rv = 32'(m_trig);
            3'd3:    rv = 32'(m_pend);
            3'd4:    rv = 32'(win + 1);
            3'd6:    rv = 32'(m_isv);
            default: rv = 32'd0;
        endcase
        np = m_pend;
        ni = m_isv;
        for (int i = 0; i < N; i++) begin
            set = m_trig[i] ? (src_irq[i] && !m_srcd[i]) : (src_irq[i] && !m_isv[i]);
            if (wr && addr == 3'd3 && wdata[i]) np[i] = 1'b0;
            if (set) np[i] = 1'b1;
            if (rd && addr == 3'd4 && win == i) begin
                if (!(m_trig[i] && set)) np[i] = 1'b0;
                ni[i] = 1'b1;
            end
        end
        if (wr && addr == 3'd5 && wdata >= 32'd1 && wdata <= 32'(N)) begin
            id = int'(wdata) - 1;
            if (m_isv[id]) ni[id] = 1'b0;
        end
        if (wr && addr == 3'd0) m_ctrl = wdata[0];
        if (wr && addr == 3'd1) m_en   = wdata[N-1:0];
        if (wr && addr == 3'd2) m_trig = wdata[N-1:0];
        if (rd) m_rdata = rv;
        m_pend = np;
        m_isv  = ni;
        m_srcd = src_irq;
    endtask

    // ---------------- helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        sel = 1'b1; wen = 1'b1; addr = a; wdata = d;
        tick();
        sel = 1'b0; wen = 1'b0; wdata = '0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        sel = 1'b1; wen = 1'b0; addr = a;
        tick();
        d = rdata;
        sel = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, d);
        check(name, d, exp);
    endtask

    typedef struct {
        logic        wr;
        logic [2:0]  a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [18];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs = '{
            '{1'b1, 3'd0, 32'hFFFF_FFFF, 32'd0},
            '{1'b0, 3'd0, 32'd0,         32'h1},
            '{1'b1, 3'd0, 32'hFFFF_FFFE, 32'd0},
            '{1'b0, 3'd0, 32'd0,         32'h0},
            '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'd0},
            '{1'b0, 3'd1, 32'd0,         32'hFF},
            '{1'b1, 3'd1, 32'h0000_0000, 32'd0},
            '{1'b0, 3'd1, 32'd0,         32'h0},
            '{1'b1, 3'd2, 32'hA5A5_A5A5, 32'd0},
            '{1'b0, 3'd2, 32'd0,         32'hA5},
            '{1'b1, 3'd2, 32'h0000_0000, 32'd0},
            '{1'b0, 3'd2, 32'd0,         32'h0},
            '{1'b0, 3'd3, 32'd0,         32'h0},
            '{1'b0, 3'd4, 32'd0,         32'h0},
            '{1'b0, 3'd5, 32'd0,         32'h0},
            '{1'b0, 3'd6, 32'd0,         32'h0},
            '{1'b1, 3'd7, 32'hFFFF_FFFF, 32'd0},
            '{1'b0, 3'd7, 32'd0,         32'h0}
        };

        rst_n = 1'b0; sel = 1'b0; wen = 1'b0; addr = '0; wdata = '0; src_irq = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_irq", 32'(irq), 32'd0);
        check("reset_rdata", rdata, 32'd0);

        for (int k = 0; k < 18; k++) begin
            if (vecs[k].wr) bus_write(vecs[k].a, vecs[k].d);
            else            read_check($sformatf("vec%0d", k), vecs[k].a, vecs[k].exp);
        end

        // Timer level interrupt and claim/complete round trip
        bus_write(3'd0, 32'd1);
        bus_write(3'd1, 32'h01);
        bus_write(3'd2, 32'h00);
        src_irq = 8'h01;
        tick(); tick();
        check("timer_irq", 32'(irq), 32'd1);
        read_check("timer_claim", 3'd4, 32'd1);
        check("timer_irq_after_claim", 32'(irq), 32'd0);
        read_check("timer_isv", 3'd6, 32'h01);
        src_irq = 8'h00;
        bus_write(3'd5, 32'd1);
        read_check("timer_isv_done", 3'd6, 32'h00);
        check("timer_irq_done", 32'(irq), 32'd0);
        src_irq = 8'h01;
        tick(); tick();
        read_check("timer_claim2", 3'd4, 32'd1);
        bus_write(3'd5, 32'd1);
        tick();
        read_check("timer_repend", 3'd3, 32'h01);
        check("timer_irq_repend", 32'(irq), 32'd1);
        read_check("timer_claim3", 3'd4, 32'd1);
        src_irq = 8'h00;
        bus_write(3'd5, 32'd1);

        // Fixed priority
        bus_write(3'd1, 32'hFF);
        src_irq = 8'h24; tick(); src_irq = 8'h00; tick();
        read_check("prio_claim1", 3'd4, 32'd3);
        check("prio_irq_mid", 32'(irq), 32'd1);
        read_check("prio_claim2", 3'd4, 32'd6);
        check("prio_irq_after", 32'(irq), 32'd0);
        read_check("prio_claim3", 3'd4, 32'd0);
        read_check("prio_isv", 3'd6, 32'h24);
        bus_write(3'd5, 32'd3);
        bus_write(3'd5, 32'd6);
        read_check("prio_isv_clear", 3'd6, 32'h00);

        // Edge latched while in service
        bus_write(3'd2, 32'h08);
        src_irq = 8'h08; tick(); src_irq = 8'h00; tick();
        read_check("edge_claim", 3'd4, 32'd4);
        src_irq = 8'h08; tick(); src_irq = 8'h00; tick();
        read_check("edge_pend_in_svc", 3'd3, 32'h08);
        check("edge_irq_in_svc", 32'(irq), 32'd0);
        bus_write(3'd5, 32'd4);
        check("edge_irq_after_complete", 32'(irq), 32'd1);
        read_check("edge_claim2", 3'd4, 32'd4);
        bus_write(3'd5, 32'd4);

        // W1C and set-versus-clear collision
        bus_write(3'd2, 32'h00);
        src_irq = 8'h06; tick(); src_irq = 8'h00; tick();
        read_check("w1c_pend_init", 3'd3, 32'h06);
        bus_write(3'd3, 32'h02);
        read_check("w1c_pend_after", 3'd3, 32'h04);
        bus_write(3'd2, 32'h04);
        src_irq = 8'h04;
        bus_write(3'd3, 32'h04);
        src_irq = 8'h00;
        read_check("w1c_set_wins", 3'd3, 32'h04);
        bus_write(3'd3, 32'hFF);
        read_check("w1c_all_clear", 3'd3, 32'h00);
        bus_write(3'd2, 32'h00);

        // Global gating and rejected completes
        bus_write(3'd0, 32'd0);
        src_irq = 8'h10; tick(); src_irq = 8'h00; tick();
        check("gate_irq_off", 32'(irq), 32'd0);
        read_check("gate_claim", 3'd4, 32'd5);
        bus_write(3'd5, 32'd0);
        read_check("bad_complete_0", 3'd6, 32'h10);
        bus_write(3'd5, 32'd9);
        read_check("bad_complete_hi", 3'd6, 32'h10);
        bus_write(3'd5, 32'd1);
        read_check("bad_complete_idle", 3'd6, 32'h10);
        bus_write(3'd5, 32'd5);
        read_check("good_complete", 3'd6, 32'h00);

        // Asynchronous reset in the middle of service
        bus_write(3'd0, 32'd1);
        bus_write(3'd1, 32'h03);
        src_irq = 8'h03;
        tick(); tick();
        read_check("rst_claim", 3'd4, 32'd1);
        check("rst_irq_before", 32'(irq), 32'd1);
        read_check("rst_isv_before", 3'd6, 32'h01);
        #3 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_irq", 32'(irq), 32'd0);
        check("rst_async_rdata", rdata, 32'd0);
        #2 rst_n = 1'b1;
        read_check("rst_isv_after", 3'd6, 32'h00);
        read_check("rst_pend_after", 3'd3, 32'h03);
        read_check("rst_ctrl_after", 3'd0, 32'h00);
        read_check("rst_en_after", 3'd1, 32'h00);
        check("rst_irq_after", 32'(irq), 32'd0);
        src_irq = 8'h00;
        bus_write(3'd3, 32'hFF);

        // Randomized traffic against the model
        bus_write(3'd0, 32'd1);
        bus_write(3'd1, 32'hFF);
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 7) == 0) src_irq[b] = ~src_irq[b];
            sel   = ($urandom_range(0, 1) == 1);
            wen   = ($urandom_range(0, 2) == 0);
            addr  = 3'($urandom_range(0, 7));
            wdata = (addr == 3'd5) ? 32'($urandom_range(0, N + 1)) : 32'($urandom);
            tick();
            check("rnd_irq", 32'(irq), 32'(m_irq()));
            check("rnd_rdata", rdata, m_rdata);
        end
        sel = 1'b0; wen = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
